// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button synchronizer, debouncer and single-cycle press pulse
//
// Raw button -> two-flop synchronizer -> four-state debounce FSM with a shared
// stability counter. 'pulse' is one cycle wide per accepted press and feeds a
// register enable downstream; 'level' is the debounced state for status LEDs.

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic pulse,
  output logic level
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1, so $clog2 bits suffice.
  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // State encoding: bit 1 set means the button is considered pressed.
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  logic          r_s1;
  logic          r_s2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;
  logic          r_level;

  logic [1:0]    w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_pulse_next;
  logic          w_level_next;
  logic          w_cnt_done;

  assign w_cnt_done = (r_cnt == CNT_MAX);

  // Two-flop synchronizer; only r_s2 is allowed to reach the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= button_in;
      r_s2 <= r_s1;
    end
  end

  // Next-state, counter and pulse decode; the counter restarts on every
  // state change and on every aborted wait so each window starts fresh.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pulse_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_s2) begin
          w_state_next = ST_WAIT_PRESS;
          w_cnt_next   = '0;
        end
      end
      ST_WAIT_PRESS: begin
        if (!r_s2) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (w_cnt_done) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
          w_pulse_next = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!r_s2) begin
          w_state_next = ST_WAIT_RELEASE;
          w_cnt_next   = '0;
        end
      end
      ST_WAIT_RELEASE: begin
        // A bounce back high simply returns to PRESSED; it is not a new press.
        if (r_s2) begin
          w_state_next = ST_PRESSED;
          w_cnt_next   = '0;
        end else if (w_cnt_done) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Level follows the state being entered, so it changes on the same edge as the FSM.
  always_comb begin
    w_level_next = (w_state_next == ST_PRESSED) || (w_state_next == ST_WAIT_RELEASE);
  end

  // FSM, counter and registered outputs; reset aborts everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pulse <= w_pulse_next;
      r_level <= w_level_next;
    end
  end

  assign pulse = r_pulse;
  assign level = r_level;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4)

module tb_button_conditioner;

  logic clock;
  logic reset;
  logic button_in;
  logic pulse;
  logic level;

  int n_cmp;
  int n_err;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .button_in (button_in),
    .pulse     (pulse),
    .level     (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    button_in = 1'b0;
    step();
    step();
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    button_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (pulse !== 1'b0 || level !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold c=%0d: pulse=%b level=%b expected 0 0", c, pulse, level);
      end
    end
    reset = 1'b0;
    for (int e = 0; e < 10; e++) begin
      logic exp_p, exp_l;
      step();
      exp_p = (e == 6);
      exp_l = (e >= 6);
      n_cmp++;
      if (pulse !== exp_p || level !== exp_l) begin
        n_err++;
        $display("FAIL reset_held_press e=%0d: pulse=%b level=%b expected %b %b", e, pulse, level, exp_p, exp_l);
      end
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    button_in = 1'b1;
    for (int e = 0; e < 20; e++) begin
      logic exp_p, exp_l;
      step();
      exp_p = (e == 6);
      exp_l = (e >= 6);
      n_cmp++;
      if (pulse !== exp_p || level !== exp_l) begin
        n_err++;
        $display("FAIL clean_press e=%0d: pulse=%b level=%b expected %b %b", e, pulse, level, exp_p, exp_l);
      end
    end
  endtask

  // Continues from the PRESSED state left by test_clean_press.
  task automatic test_clean_release();
    button_in = 1'b0;
    for (int e = 0; e < 14; e++) begin
      logic exp_l;
      step();
      exp_l = (e < 6);
      n_cmp++;
      if (pulse !== 1'b0 || level !== exp_l) begin
        n_err++;
        $display("FAIL clean_release e=%0d: pulse=%b level=%b expected 0 %b", e, pulse, level, exp_l);
      end
    end
  endtask

  task automatic test_press_bounce();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      button_in = ((i % 4) != 3);
      step();
      n_cmp++;
      if (pulse !== 1'b0 || level !== 1'b0) begin
        n_err++;
        $display("FAIL press_bounce i=%0d: pulse=%b level=%b expected 0 0", i, pulse, level);
      end
    end
  endtask

  task automatic test_release_bounce();
    int n_pulse;
    do_reset();
    n_pulse   = 0;
    button_in = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (pulse === 1'b1) n_pulse++;
    end
    n_cmp++;
    if (n_pulse != 1 || level !== 1'b1) begin
      n_err++;
      $display("FAIL release_bounce_press: pulses=%0d level=%b expected 1 1", n_pulse, level);
    end
    for (int i = 0; i < 30; i++) begin
      button_in = ((i % 3) == 2);
      step();
      n_cmp++;
      if (pulse !== 1'b0 || level !== 1'b1) begin
        n_err++;
        $display("FAIL release_bounce i=%0d: pulse=%b level=%b expected 0 1", i, pulse, level);
      end
    end
    button_in = 1'b0;
    for (int e = 0; e < 12; e++) begin
      logic exp_l;
      step();
      exp_l = (e < 6);
      n_cmp++;
      if (pulse !== 1'b0 || level !== exp_l) begin
        n_err++;
        $display("FAIL release_bounce_final e=%0d: pulse=%b level=%b expected 0 %b", e, pulse, level, exp_l);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    button_in = 1'b1;
    for (int e = 0; e <= 4; e++) step();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pulse !== 1'b0 || level !== 1'b0) begin
      n_err++;
      $display("FAIL mid_count_async: pulse=%b level=%b expected 0 0", pulse, level);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (pulse !== 1'b0 || level !== 1'b0) begin
        n_err++;
        $display("FAIL mid_count_hold c=%0d: pulse=%b level=%b expected 0 0", c, pulse, level);
      end
    end
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      logic exp_p, exp_l;
      step();
      exp_p = (e == 6);
      exp_l = (e >= 6);
      n_cmp++;
      if (pulse !== exp_p || level !== exp_l) begin
        n_err++;
        $display("FAIL mid_count_repress e=%0d: pulse=%b level=%b expected %b %b", e, pulse, level, exp_p, exp_l);
      end
    end

    // Reset landing while pulse is high must drop it before the next edge.
    do_reset();
    button_in = 1'b1;
    for (int e = 0; e <= 6; e++) step();
    n_cmp++;
    if (pulse !== 1'b1 || level !== 1'b1) begin
      n_err++;
      $display("FAIL pulse_before_reset: pulse=%b level=%b expected 1 1", pulse, level);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pulse !== 1'b0 || level !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_async_drop: pulse=%b level=%b expected 0 0", pulse, level);
    end
    step();
    reset     = 1'b0;
    button_in = 1'b0;
    step();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    button_in = 1'b0;
    test_reset();
    test_clean_press();
    test_clean_release();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
